// File: rtl/prbs_pkg.sv
// Shared types and helpers for the pattern/PRBS stimulus generator.
// Holds the FSM state encoding, the LFSR tap lookup and the order legality check.
package prbs_pkg;

   typedef enum logic [1:0] {IDLE, READY, REPEAT, SCRAMBLE} prbs_state_e;

   // Second feedback tap (1-based) for each supported LFSR order; 0 marks an illegal order.
   function automatic int prbs_tap(input int order);
      case (order)
         7:       return 6;
         15:      return 14;
         23:      return 18;
         31:      return 28;
         default: return 0;
      endcase
   endfunction

   function automatic bit prbs_order_ok(input int order);
      return prbs_tap(order) != 0;
   endfunction

endpackage

// File: rtl/prbs_lfsr_par.sv
// Unrolled Fibonacci LFSR: advances STEP_W steps in one cycle and returns the
// produced bits LSB first. Purely combinational; the state register lives in the parent.
module prbs_lfsr_par
   import prbs_pkg::*;
#(
   parameter int ORDER  = 15,
   parameter int STEP_W = 8
) (
   input  logic [ORDER-1:0]  state_i,
   output logic [ORDER-1:0]  state_o,
   output logic [STEP_W-1:0] word_o
);

   localparam int TAP = prbs_tap(ORDER);

   logic [ORDER-1:0] s;
   logic             fb;

   always_comb begin
      s      = state_i;
      fb     = 1'b0;
      word_o = '0;
      for (int i = 0; i < STEP_W; i++) begin
         fb        = s[ORDER-1] ^ s[TAP-1];
         word_o[i] = fb;
         s         = {s[ORDER-2:0], fb};
      end
      state_o = s;
   end

endmodule

// File: rtl/prbs_pattern_gen.sv
// Captures a PAT_DEPTH-word pattern, replays it n times verbatim (flagging the last
// word), then streams it XORed with a PRBS until aborted. All outputs are registered.
module prbs_pattern_gen
   import prbs_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int PAT_DEPTH  = 4,
   parameter int CNT_W      = 3,
   parameter int PRBS_ORDER = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   input  logic              start,
   input  logic [CNT_W-1:0]  n,
   input  logic              abort,
   output logic              out_valid,
   output logic [DATA_W-1:0] data_random,
   output logic              data_flag,
   output logic              busy
);

   localparam int              IDX_W    = $clog2(PAT_DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_DEPTH - 1);

   if (!prbs_order_ok(PRBS_ORDER)) begin : g_bad_order
      $error("prbs_pattern_gen: PRBS_ORDER must be 7, 15, 23 or 31");
   end

   prbs_state_e           state_q;
   logic [DATA_W-1:0]     pat_q [PAT_DEPTH];
   logic [IDX_W-1:0]      idx_q;
   logic [CNT_W-1:0]      rep_q, n_q;
   logic [PRBS_ORDER-1:0] lfsr_q;
   logic                  out_valid_q, flag_q;
   logic [DATA_W-1:0]     data_q;

   logic [IDX_W-1:0]      cur_idx, idx_d;
   logic [CNT_W-1:0]      cur_rep, cur_n, rep_d;
   logic [PRBS_ORDER-1:0] cur_lfsr, lfsr_nxt;
   logic [DATA_W-1:0]     prbs_word, data_d;
   logic                  emit_rep, emit_scr, last_word, last_rep;

   // On the start cycle the first word is produced from freshly cleared counters and
   // a reseeded LFSR, so these "current" values stand in for the registers.
   always_comb begin
      cur_idx  = idx_q;
      cur_rep  = rep_q;
      cur_n    = n_q;
      cur_lfsr = lfsr_q;
      emit_rep = 1'b0;
      emit_scr = 1'b0;
      case (state_q)
         READY: if (start) begin
            cur_idx  = '0;
            cur_rep  = '0;
            cur_n    = n;
            cur_lfsr = '1;
            emit_rep = (n != '0);
            emit_scr = (n == '0);
         end
         REPEAT:   emit_rep = !abort;
         SCRAMBLE: emit_scr = !abort;
         default: ;
      endcase
      last_word = (cur_idx == LAST_IDX);
      last_rep  = (cur_rep == cur_n - CNT_W'(1));
      idx_d     = last_word ? '0 : cur_idx + IDX_W'(1);
      rep_d     = (emit_rep && last_word) ? cur_rep + CNT_W'(1) : cur_rep;
      data_d    = '0;
      if (emit_rep)      data_d = pat_q[cur_idx];
      else if (emit_scr) data_d = pat_q[cur_idx] ^ prbs_word;
   end

   prbs_lfsr_par #(
      .ORDER  (PRBS_ORDER),
      .STEP_W (DATA_W)
   ) u_lfsr (
      .state_i (cur_lfsr),
      .state_o (lfsr_nxt),
      .word_o  (prbs_word)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         for (int i = 0; i < PAT_DEPTH; i++) pat_q[i] <= '0;
         idx_q       <= '0;
         rep_q       <= '0;
         n_q         <= '0;
         lfsr_q      <= '1;
         out_valid_q <= 1'b0;
         flag_q      <= 1'b0;
         data_q      <= '0;
      end else begin
         out_valid_q <= emit_rep || emit_scr;
         flag_q      <= emit_rep && last_word && last_rep;
         data_q      <= data_d;
         case (state_q)
            IDLE: if (load_valid) begin
               pat_q[idx_q] <= load_data;
               idx_q        <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
               if (idx_q == LAST_IDX) state_q <= READY;
            end
            READY: if (start) begin
               n_q     <= n;
               state_q <= (n != '0) ? REPEAT : SCRAMBLE;
            end
            REPEAT, SCRAMBLE: if (abort) state_q <= READY;
            default: state_q <= IDLE;
         endcase
         if (emit_rep || emit_scr) begin
            idx_q  <= idx_d;
            rep_q  <= rep_d;
            lfsr_q <= emit_scr ? lfsr_nxt : cur_lfsr;
            if (emit_rep && last_word && last_rep) state_q <= SCRAMBLE;
         end
      end
   end

   assign out_valid   = out_valid_q;
   assign data_random = data_q;
   assign data_flag   = flag_q;
   assign busy        = (state_q == REPEAT) || (state_q == SCRAMBLE);

endmodule

// File: tb/tb_prbs_pattern_gen.sv
// Bench for prbs_pattern_gen: an 8-bit/depth-4/PRBS-15 instance and a
// 1-bit/depth-3/PRBS-7 instance, checked cycle by cycle through an expected queue.
module tb_prbs_pattern_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       a_rst, a_lv, a_st, a_ab, a_ov, a_fl, a_bz;
   logic [7:0] a_ld, a_dr;
   logic [2:0] a_n;

   logic       b_rst, b_lv, b_st, b_ab, b_ov, b_fl, b_bz;
   logic [0:0] b_ld, b_dr;
   logic [2:0] b_n;

   prbs_pattern_gen #(.DATA_W(8), .PAT_DEPTH(4), .CNT_W(3), .PRBS_ORDER(15)) dut_a (
      .clk(clk), .rst(a_rst), .load_valid(a_lv), .load_data(a_ld), .start(a_st), .n(a_n),
      .abort(a_ab), .out_valid(a_ov), .data_random(a_dr), .data_flag(a_fl), .busy(a_bz));

   prbs_pattern_gen #(.DATA_W(1), .PAT_DEPTH(3), .CNT_W(3), .PRBS_ORDER(7)) dut_b (
      .clk(clk), .rst(b_rst), .load_valid(b_lv), .load_data(b_ld), .start(b_st), .n(b_n),
      .abort(b_ab), .out_valid(b_ov), .data_random(b_dr), .data_flag(b_fl), .busy(b_bz));

   typedef struct {
      logic       r, lv;
      logic [7:0] ld;
      logic       st;
      logic [2:0] nn;
      logic       ab, ev, ef, eb;
      logic [7:0] ed;
   } vec_t;

   int         vec_cnt  = 0;
   int         miss_cnt = 0;
   logic [10:0] exp_q[$];
   bit         hist[$];
   logic [7:0] pat_a[4];
   logic       pat_b[3];
   vec_t       tbl[16];

   function automatic vec_t mk(input logic r, input logic lv, input logic [7:0] ld,
                               input logic st, input logic [2:0] nn, input logic ab,
                               input logic ev, input logic ef, input logic eb,
                               input logic [7:0] ed);
      vec_t v;
      v.r = r; v.lv = lv; v.ld = ld; v.st = st; v.nn = nn; v.ab = ab;
      v.ev = ev; v.ef = ef; v.eb = eb; v.ed = ed;
      return v;
   endfunction

   // Reference PRBS: out[k] = out[k-ORDER] ^ out[k-TAP], with the history preset to ones.
   task automatic reseed(input int order);
      hist.delete();
      for (int i = 0; i < order; i++) hist.push_back(1'b1);
   endtask

   task automatic next_word(input int order, input int tap, input int width, output logic [7:0] w);
      bit b;
      w = '0;
      for (int i = 0; i < width; i++) begin
         b = hist[0] ^ hist[order - tap];
         hist.push_back(b);
         void'(hist.pop_front());
         w[i] = b;
      end
   endtask

   task automatic check(input string name, input logic [10:0] act);
      logic [10:0] e;
      if (exp_q.size() == 0) begin
         miss_cnt++;
         $display("FAIL %s: expected queue empty, got %h", name, act);
         return;
      end
      e = exp_q.pop_front();
      vec_cnt++;
      if (act !== e) begin
         miss_cnt++;
         $display("FAIL %s: got valid=%b flag=%b busy=%b data=%h, expected valid=%b flag=%b busy=%b data=%h",
                  name, act[10], act[9], act[8], act[7:0], e[10], e[9], e[8], e[7:0]);
      end
   endtask

   task automatic cyc_a(input string name, input logic r, input logic lv, input logic [7:0] ld,
                        input logic st, input logic [2:0] nn, input logic ab,
                        input logic ev, input logic ef, input logic eb, input logic [7:0] ed);
      a_rst = r; a_lv = lv; a_ld = ld; a_st = st; a_n = nn; a_ab = ab;
      exp_q.push_back({ev, ef, eb, ed});
      @(posedge clk); #1;
      check(name, {a_ov, a_fl, a_bz, a_dr});
      a_rst = 1'b0; a_lv = 1'b0; a_st = 1'b0; a_ab = 1'b0;
   endtask

   task automatic cyc_b(input string name, input logic r, input logic lv, input logic ld,
                        input logic st, input logic [2:0] nn, input logic ab,
                        input logic ev, input logic ef, input logic eb, input logic ed);
      b_rst = r; b_lv = lv; b_ld = ld; b_st = st; b_n = nn; b_ab = ab;
      exp_q.push_back({ev, ef, eb, 7'd0, ed});
      @(posedge clk); #1;
      check(name, {b_ov, b_fl, b_bz, 7'd0, b_dr});
      b_rst = 1'b0; b_lv = 1'b0; b_st = 1'b0; b_ab = 1'b0;
   endtask

   // Free-running SCRAMBLE words for instance A, k counted from the first scrambled word.
   task automatic scr_a(input string name, input int skip, input int cnt);
      logic [7:0] w;
      reseed(15);
      for (int k = 0; k < skip + cnt; k++) begin
         next_word(15, 14, 8, w);
         if (k >= skip)
            cyc_a($sformatf("%s[%0d]", name, k), 0, 0, 8'h00, 0, 3'd0, 0, 1, 0, 1, pat_a[k % 4] ^ w);
      end
   endtask

   task automatic scr_b(input string name, input int cnt);
      logic [7:0] w;
      reseed(7);
      for (int k = 0; k < cnt; k++) begin
         next_word(7, 6, 1, w);
         cyc_b($sformatf("%s[%0d]", name, k), 0, 0, 1'b0, 0, 3'd0, 0, 1, 0, 1, pat_b[k % 3] ^ w[0]);
      end
   endtask

   initial begin
      a_rst = 1'b0; a_lv = 1'b0; a_ld = '0; a_st = 1'b0; a_n = '0; a_ab = 1'b0;
      b_rst = 1'b0; b_lv = 1'b0; b_ld = '0; b_st = 1'b0; b_n = '0; b_ab = 1'b0;
      pat_a = '{8'hCC, 8'hDD, 8'hEE, 8'hFF};

      // Reset, load, ignored inputs in READY, start n=2, REPEAT and first SCRAMBLE words.
      tbl[0]  = mk(1, 0, 8'h00, 0, 3'd0, 0, 0, 0, 0, 8'h00);
      tbl[1]  = mk(0, 1, 8'hCC, 0, 3'd0, 1, 0, 0, 0, 8'h00);
      tbl[2]  = mk(0, 1, 8'hDD, 1, 3'd2, 0, 0, 0, 0, 8'h00);
      tbl[3]  = mk(0, 1, 8'hEE, 0, 3'd0, 0, 0, 0, 0, 8'h00);
      tbl[4]  = mk(0, 1, 8'hFF, 0, 3'd0, 0, 0, 0, 0, 8'h00);
      tbl[5]  = mk(0, 1, 8'h55, 0, 3'd0, 1, 0, 0, 0, 8'h00);
      tbl[6]  = mk(0, 0, 8'h00, 1, 3'd2, 0, 1, 0, 1, 8'hCC);
      tbl[7]  = mk(0, 0, 8'h00, 0, 3'd0, 0, 1, 0, 1, 8'hDD);
      tbl[8]  = mk(0, 1, 8'h77, 1, 3'd5, 0, 1, 0, 1, 8'hEE);
      tbl[9]  = mk(0, 0, 8'h00, 0, 3'd0, 0, 1, 0, 1, 8'hFF);
      tbl[10] = mk(0, 0, 8'h00, 0, 3'd0, 0, 1, 0, 1, 8'hCC);
      tbl[11] = mk(0, 0, 8'h00, 0, 3'd0, 0, 1, 0, 1, 8'hDD);
      tbl[12] = mk(0, 0, 8'h00, 0, 3'd0, 0, 1, 0, 1, 8'hEE);
      tbl[13] = mk(0, 0, 8'h00, 0, 3'd0, 0, 1, 1, 1, 8'hFF);
      tbl[14] = mk(0, 0, 8'h00, 0, 3'd0, 0, 1, 0, 1, 8'hCC);
      tbl[15] = mk(0, 0, 8'h00, 0, 3'd0, 0, 1, 0, 1, 8'h9D);
      for (int i = 0; i < 16; i++)
         cyc_a($sformatf("base[%0d]", i), tbl[i].r, tbl[i].lv, tbl[i].ld, tbl[i].st, tbl[i].nn,
               tbl[i].ab, tbl[i].ev, tbl[i].ef, tbl[i].eb, tbl[i].ed);
      scr_a("base_scr", 2, 20);
      cyc_a("abort1", 0, 0, 8'h00, 0, 3'd0, 1, 0, 0, 0, 8'h00);
      cyc_a("ready_idle", 0, 0, 8'h00, 0, 3'd0, 0, 0, 0, 0, 8'h00);

      // Restart with n=1, no reload; abort together with an ignored start in SCRAMBLE.
      for (int i = 0; i < 4; i++)
         cyc_a($sformatf("rerun[%0d]", i), 0, 0, 8'h00, (i == 0), 3'd1, 0, 1, (i == 3), 1, pat_a[i]);
      scr_a("rerun_scr", 0, 6);
      cyc_a("abort2", 0, 0, 8'h00, 1, 3'd3, 1, 0, 0, 0, 8'h00);

      // n=0 with a simultaneous abort: start wins and the first word is already scrambled.
      cyc_a("n0_first", 0, 0, 8'h00, 1, 3'd0, 1, 1, 0, 1, 8'hCC);
      scr_a("n0_scr", 1, 15);
      cyc_a("abort3", 0, 0, 8'h00, 0, 3'd0, 1, 0, 0, 0, 8'h00);

      // Maximum count: 28 verbatim words, one flag.
      for (int i = 0; i < 28; i++)
         cyc_a($sformatf("max[%0d]", i), 0, 0, 8'h00, (i == 0), 3'd7, 0, 1, (i == 27), 1, pat_a[i % 4]);
      scr_a("max_scr", 0, 3);
      cyc_a("abort4", 0, 0, 8'h00, 0, 3'd0, 1, 0, 0, 0, 8'h00);

      // Reset mid-REPEAT: everything clears, start ignored until a full reload.
      for (int i = 0; i < 5; i++)
         cyc_a($sformatf("pre_rst[%0d]", i), 0, 0, 8'h00, (i == 0), 3'd3, 0, 1, 0, 1, pat_a[i % 4]);
      cyc_a("mid_rst", 1, 0, 8'h00, 0, 3'd0, 0, 0, 0, 0, 8'h00);
      cyc_a("idle_start", 0, 0, 8'h00, 1, 3'd1, 0, 0, 0, 0, 8'h00);
      pat_a = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 3; i++)
         cyc_a($sformatf("reload[%0d]", i), 0, 1, pat_a[i], 0, 3'd0, 0, 0, 0, 0, 8'h00);
      cyc_a("partial_start", 0, 0, 8'h00, 1, 3'd1, 0, 0, 0, 0, 8'h00);
      cyc_a("reload[3]", 0, 1, pat_a[3], 0, 3'd0, 0, 0, 0, 0, 8'h00);
      for (int i = 0; i < 4; i++)
         cyc_a($sformatf("new_pat[%0d]", i), 0, 0, 8'h00, (i == 0), 3'd1, 0, 1, (i == 3), 1, pat_a[i]);
      scr_a("new_scr", 0, 2);
      cyc_a("abort5", 0, 0, 8'h00, 0, 3'd0, 1, 0, 0, 0, 8'h00);

      // Depth-3 wrap 0,1,2,0 on the 1-bit PRBS-7 instance.
      pat_b = '{1'b1, 1'b0, 1'b1};
      cyc_b("b_rst", 1, 0, 1'b0, 0, 3'd0, 0, 0, 0, 0, 1'b0);
      for (int i = 0; i < 3; i++)
         cyc_b($sformatf("b_load[%0d]", i), 0, 1, pat_b[i], 0, 3'd0, 0, 0, 0, 0, 1'b0);
      for (int i = 0; i < 6; i++)
         cyc_b($sformatf("b_wrap[%0d]", i), 0, 0, 1'b0, (i == 0), 3'd2, 0, 1, (i == 5), 1, pat_b[i % 3]);
      scr_b("b_scr", 9);
      cyc_b("b_abort", 0, 0, 1'b0, 0, 3'd0, 1, 0, 0, 0, 1'b0);

      // All-zero pattern: the output is the raw PRBS-7 stream, two full periods.
      pat_b = '{1'b0, 1'b0, 1'b0};
      cyc_b("b_rst2", 1, 0, 1'b0, 0, 3'd0, 0, 0, 0, 0, 1'b0);
      for (int i = 0; i < 3; i++)
         cyc_b($sformatf("b_zload[%0d]", i), 0, 1, 1'b0, 0, 3'd0, 0, 0, 0, 0, 1'b0);
      begin
         logic [7:0] w;
         reseed(7);
         for (int k = 0; k < 254; k++) begin
            next_word(7, 6, 1, w);
            cyc_b($sformatf("b_prbs7[%0d]", k), 0, 0, 1'b0, (k == 0), 3'd0, 0, 1, 0, 1, w[0]);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule

// File: doc/prbs_pattern_gen.md
# prbs_pattern_gen

Parametrised pattern/PRBS stimulus generator for the PRBS test path. It captures a short user pattern, replays it verbatim a programmable number of times, and flags completion of the replay. It then streams the pattern scrambled with a selectable-order PRBS until aborted. It sits between the host-side pattern loader and the serializer/sequence-detector chain, and supersedes the fixed 8-bit, 4-word, PRBS-15-only generator.

## Interface
Parameters:
- DATA_W, 8: output/pattern word width, 1..32.
- PAT_DEPTH, 4: number of pattern words, 2..16.
- CNT_W, 3: width of the repeat count `n`.
- PRBS_ORDER, 15: LFSR order. Legal values are 7, 15, 23 and 31; any other value is a synthesis-time error.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  `load_data` is valid this cycle (used in IDLE only).
- load_data  in  DATA_W  next pattern word, index 0 first.
- start  in  1  begin a run (used in READY only).
- n  in  CNT_W  number of verbatim repetitions; sampled on the cycle `start` is accepted.
- abort  in  1  end the current run and return to READY.
- out_valid  out  1  `data_random` is valid this cycle.
- data_random  out  DATA_W  output word.
- data_flag  out  1  one-cycle pulse on the final word of the last verbatim repetition.
- busy  out  1  high in REPEAT or SCRAMBLE.

## Operation
- **Reset values:** state=IDLE, all outputs 0, pattern registers 0, load index 0, LFSR = all ones.
- **IDLE:** each `load_valid` cycle writes `pat[idx]` and increments `idx`. The write at idx=PAT_DEPTH-1 moves the block to READY.
- **READY:**
  - `start` latches `n`, reseeds the LFSR to all ones and clears the word and repetition counters.
  - If n≠0, go to REPEAT; if n=0, go straight to SCRAMBLE and never pulse `data_flag`.
- **REPEAT:**
  - Emits `pat[0..PAT_DEPTH-1]` cyclically, one word per cycle, with `out_valid`=1.
  - On word PAT_DEPTH-1 of repetition n, `data_flag` pulses with that word and the next state is SCRAMBLE.
  - The LFSR does not advance in REPEAT.
- **SCRAMBLE:** emits `pat[k mod PAT_DEPTH] XOR prbs_word` every cycle indefinitely; the LFSR advances DATA_W steps per word.
- **abort:** in REPEAT or SCRAMBLE, returns to READY next cycle with `out_valid`=0. The pattern is retained, so a new `start` needs no reload.
- **Ignored inputs:** `abort` in IDLE/READY; `start` outside READY; `load_valid` outside IDLE. Reloading a pattern requires `rst`.
- **Simultaneous start and abort in READY:** `start` wins.
- **LFSR (Fibonacci):**
  - Feedback per step: fb = s[ORDER-1] ^ s[TAP-1], then s ← {s[ORDER-2:0], fb}.
  - TAP is 6, 14, 18 or 28 for orders 7, 15, 23 and 31 respectively.
  - Step i of a word (i=0 first) produces bit i of `prbs_word` (LSB first) and equals fb.
- **Counters:** the repetition counter is CNT_W wide and compared against the latched `n`, so `n` = 2^CNT_W-1 is legal. The word index wraps modulo PAT_DEPTH, including non-power-of-2 depths.

## Timing
- Load: one word per cycle, back-to-back allowed. READY is entered the cycle after the final write.
- Start latency: `start` accepted at edge t → first word has `out_valid`=1 in cycle t+1. The output is registered.
- REPEAT lasts exactly n·PAT_DEPTH cycles. The first SCRAMBLE word immediately follows the `data_flag` cycle with no bubble.
- `abort` at edge t → `out_valid`=0 and `busy`=0 from cycle t+1.
- `rst` mid-run: at the next edge all state returns to reset values and the pattern is cleared.

## Structure
- Package `prbs_pkg` holds:
  - the state enum {IDLE, READY, REPEAT, SCRAMBLE};
  - the tap lookup function `prbs_tap(order)`;
  - a legality check on order.
- Sub-module `prbs_lfsr_par`: parameters ORDER and STEP_W. It is a combinational unrolled STEP_W-step next-state and output-word function. The state register stays in the parent.

## Test plan
- **Baseline, PRBS-15:** load CC,DD,EE,FF, then start with n=2.
  - REPEAT outputs CC DD EE FF CC DD EE FF, with `data_flag` pulsing on the 8th word.
  - The first SCRAMBLE words are CC (CC^00), then 9D (DD^40).
- **n=0:** the first output word is already scrambled (CC), and `data_flag` never pulses.
- **Max count:** CNT_W=3, n=7 → exactly 28 REPEAT words and a single `data_flag` pulse.
- **Abort/restart:**
  - Abort during SCRAMBLE → `out_valid`=0 next cycle.
  - A second start with n=1 reproduces the identical sequence without reloading.
- **PRBS-7, DATA_W=1, all-zero pattern:** the SCRAMBLE stream has period 127 and matches the reference x^7+x^6+1 model.
- **Reset mid-REPEAT:**
  - All outputs are 0 on the next cycle, the block is in IDLE, and `start` is ignored until four new words are loaded.
  - Non-power-of-2 depth: with PAT_DEPTH=3, the word index wraps 0,1,2,0.
